// File: rtl/hazard_unit.sv
// Pipeline hazard control for a 5-stage RISC-V core: EX operand forwarding, load-use bubbles,
// branch flushes, data-memory wait freezing with timeout fault, and saturating perf counters.
module hazard_unit #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             DMemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1) + 1;

    typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cycles_reg, flush_count_reg;
    logic              redirect;
    logic              lu;
    logic              freeze;

    // M-stage result is younger than W, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)
            return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign freeze = MemAccessM & ~DMemReadyM;
    assign lu     = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    always_comb begin
        ForwardAE     = fwd_sel(Rs1E);
        ForwardBE     = fwd_sel(Rs2E);
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;
        redirect      = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        unique case (state_reg)
            RUN, MWAIT: begin
                if ((state_reg == RUN && freeze) || (state_reg == MWAIT && !DMemReadyM)) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (state_reg == RUN) begin
                        state_next    = MWAIT;
                        wait_cnt_next = WAIT_W'(1);
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                        if (wait_cnt_next >= WAIT_W'(WAIT_MAX))
                            state_next = FAULT;
                    end
                end else begin
                    // A redirect squashes the dependent instruction, so no bubble is needed.
                    if (PCSrcE) begin
                        FlushD   = 1'b1;
                        FlushE   = 1'b1;
                        redirect = 1'b1;
                    end else if (lu) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            FAULT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end
            default: state_next = RUN;
        endcase

        if (rst) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            redirect  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (StallF && stall_cycles_reg != '1)
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            if (redirect && flush_count_reg != '1)
                flush_count_reg <= flush_count_reg + CNT_W'(1);
        end
    end

    assign fault        = (state_reg == FAULT);
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule
